// File: rtl/mem_readback.sv
// mem_readback: streams a contiguous range of data-memory words out of a
// valid/ready port, one word per transfer. Words containing an illegal trit
// encoding (2'b11) set a sticky bad_trit flag. The block drives the memory
// port only while busy is high.
//
// State table:
//   IDLE | waiting for start; bad_trit and last output word are retained
//   READ | mem_read strobe high for one cycle at mem_address
//   WAIT | memory returns data this cycle; captured on the way to HOLD
//   HOLD | out_valid high, waiting for the consumer handshake
//   DONE | one-cycle done pulse, busy still high
//
// Ports:
//   clock, reset        system clock; synchronous active-low reset
//   start               begin a readback (sampled in IDLE only)
//   base_addr           first word address, captured on accepted start
//   word_count          number of words, captured on accepted start
//   mem_read            one-cycle read strobe to memory
//   mem_address         read address
//   mem_read_data       read data, valid the cycle after mem_read
//   out_valid/out_ready output handshake
//   out_data, out_addr  captured word and its address
//   out_last            marks the final word of the range
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   bad_trit            sticky illegal-encoding flag for the current range
module mem_readback #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  bad_trit
);

  localparam int TRITS = DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  last_word;
  logic                  word_bad;

  // Natural width overflow gives the required wrap from all-ones to zero.
  assign addr_inc  = addr + ADDR_WIDTH'(1);
  assign last_word = (remaining == ADDR_WIDTH'(1));

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < TRITS; i++) begin
      if (mem_read_data[2*i +: 2] == 2'b11) word_bad = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bad_trit    <= 1'b0;
    end else begin
      // Strobes default low; each is raised only on the edge entering its state.
      mem_read <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= word_count;
            bad_trit  <= 1'b0;
            busy      <= 1'b1;
            if (word_count != '0) begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_address <= base_addr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_data  <= mem_read_data;
          out_addr  <= addr;
          out_last  <= last_word;
          if (word_bad) bad_trit <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            addr      <= addr_inc;
            remaining <= remaining - ADDR_WIDTH'(1);
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_address <= addr_inc;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_readback.sv
// Self-checking bench for mem_readback: a table of bursts driven through a
// behavioural memory, with a scoreboard of expected words popped on each
// output handshake, plus hand-written reset sequences.
module tb_mem_readback;

  localparam int DW = 18;
  localparam int AW = 18;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_read_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          bad_trit;

  always #5 clock = ~clock;

  mem_readback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .mem_read      (mem_read),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .bad_trit      (bad_trit)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];

  // Unprogrammed locations hold legal trits (only 00 / 01 pairs).
  function automatic logic [DW-1:0] mem_at(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (mem.exists(a)) return mem[a];
    v = '0;
    for (int i = 0; i < 9; i++) v[2*i] = a[i] ^ a[i+9];
    return v;
  endfunction

  always @(posedge clock) begin
    if (mem_read) mem_read_data <= mem_at(mem_address);
  end

  // ---------------- bookkeeping ----------------
  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int reads      = 0;
  int last_hs    = -1;
  logic gap_en   = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    int            stall;
    logic          poke;
    logic          exp_bad;
  } vec_t;

  // ---------------- output monitor ----------------
  logic          held_valid = 1'b0;
  logic [DW-1:0] held_data;
  logic [AW-1:0] held_addr;
  logic          held_last;

  always @(negedge clock) begin
    if (reset) begin
      if (mem_read) reads++;
      if (out_valid && held_valid) begin
        check("stall_data", out_data, held_data);
        check("stall_addr", out_addr, held_addr);
        check("stall_last", out_last, held_last);
      end
      if (out_valid && !out_ready) begin
        held_valid = 1'b1;
        held_data  = out_data;
        held_addr  = out_addr;
        held_last  = out_last;
      end else begin
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: addr %0h data %0h with empty scoreboard", out_addr, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", out_data, e.data);
          check("word_addr", out_addr, e.addr);
          check("word_last", out_last, e.last);
        end
        if (gap_en && last_hs >= 0) check("xfer_gap", cyc - last_hs, 3);
        last_hs = cyc;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  // ---------------- sequences ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},    mem_read, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_out_valid"},   out_valid, 0);
    check({tag, "_out_data"},    out_data, 0);
    check({tag, "_out_addr"},    out_addr, 0);
    check({tag, "_out_last"},    out_last, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_done"},        done, 0);
    check({tag, "_bad_trit"},    bad_trit, 0);
  endtask

  task automatic run_burst(input vec_t v);
    logic [AW-1:0] a;
    int t0, first_v, done_c, stall_ctr, reads0, budget;
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = v.base + AW'(i);
      sb.push_back('{mem_at(a), a, (i == int'(v.cnt) - 1)});
    end
    gap_en    = (v.stall == 0);
    last_hs   = -1;
    reads0    = reads;
    first_v   = -1;
    done_c    = -1;
    stall_ctr = 0;
    out_ready  = (v.stall == 0);
    base_addr  = v.base;
    word_count = v.cnt;
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    t0 = cyc;
    check("start_busy", busy, 1);
    if (v.cnt == 0) begin
      check("zero_done", done, 1);
      done_c = t0;
    end else begin
      check("first_read", mem_read, 1);
      check("first_addr", mem_address, v.base);
    end
    budget = 300;
    while (done_c < 0 && budget > 0) begin
      @(posedge clock); #1;
      budget--;
      if (mem_read && sb.size() > 0) check("rd_addr", mem_address, sb[0].addr);
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        check("first_valid_lat", cyc - t0, 2);
      end
      if (out_valid) begin
        if (stall_ctr < v.stall) begin
          out_ready = 1'b0;
          stall_ctr++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = (v.stall == 0);
        stall_ctr = 0;
      end
      start = v.poke && ((cyc == t0 + 1) || (out_valid && !out_ready));
      if (v.poke) begin
        base_addr  = 18'h300;
        word_count = 18'd7;
      end
      if (done) begin
        done_c = cyc;
        check("done_lat", cyc - last_hs, 1);
      end
    end
    check("done_seen", (done_c >= 0), 1);
    start     = 1'b0;
    out_ready = 1'b0;
    check("busy_in_done", busy, 1);
    check("done_bad_trit", bad_trit, v.exp_bad);
    @(posedge clock); #1;
    check("done_pulse", done, 0);
    check("busy_fall", busy, 0);
    check("bad_sticky", bad_trit, v.exp_bad);
    check("read_count", reads - reads0, v.cnt);
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  vec_t vt[7];

  initial begin
    int b;
    mem[18'h20] = 18'h00001;
    mem[18'h21] = 18'h00002;
    mem[18'h22] = 18'h2AAAA;
    mem[18'h23] = 18'h15555;
    mem[18'h05] = 18'h00003;
    mem[18'h41] = 18'h30000;

    //          base      cnt    stall poke  bad
    vt[0] = '{18'h00020, 18'd4, 0, 1'b0, 1'b0};
    vt[1] = '{18'h00020, 18'd4, 5, 1'b0, 1'b0};
    vt[2] = '{18'h00005, 18'd1, 0, 1'b0, 1'b1};
    vt[3] = '{18'h00000, 18'd0, 0, 1'b0, 1'b0};
    vt[4] = '{18'h3FFFE, 18'd3, 0, 1'b0, 1'b0};
    vt[5] = '{18'h00040, 18'd3, 1, 1'b0, 1'b1};
    vt[6] = '{18'h00020, 18'd4, 3, 1'b1, 1'b0};

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("por");
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) run_burst(vt[i]);

    // Reset while a word is held: everything clears and the block is idle.
    base_addr  = 18'h10;
    word_count = 18'd4;
    out_ready  = 1'b0;
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    b = 0;
    while (!out_valid && b < 20) begin
      @(posedge clock); #1;
      b++;
    end
    check("hold_reached", out_valid, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    check_all_zero("midrst");
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("postrst");
    run_burst('{18'h00010, 18'd2, 0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_readback.md
# mem_readback

Memory readback unit for the ternary system: the read-side counterpart of the program loader. After execution it streams a contiguous range of data-memory words out through a valid/ready port, one word per transfer. It also flags words containing illegal trit encodings, so benches and host links can dump and check final memory state without probing the hierarchy. It sits beside the loader on the system memory port and owns that port only while `busy` is high.

## Interface
- `DATA_WIDTH`, 18, word width; 9 trits at 2 bits per trit.
- `ADDR_WIDTH`, 18, memory address width.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (low at a rising edge resets the block).
- `start`  in  1  begin readback; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address; captured on accepted `start`.
- `word_count`  in  ADDR_WIDTH  number of words; captured on accepted `start`.
- `mem_read`  out  1  read strobe to memory.
- `mem_address`  out  ADDR_WIDTH  read address.
- `mem_read_data`  in  DATA_WIDTH  read data, valid the cycle after `mem_read`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  captured word.
- `out_addr`  out  ADDR_WIDTH  address of `out_data`.
- `out_last`  out  1  marks the final word of the range.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `bad_trit`  out  1  sticky flag: any streamed word held the encoding 2'b11.

## Operation
- Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = −1, 2'b11 = illegal.
- States and transitions:
  - IDLE → READ on `start` when `word_count` ≠ 0.
  - IDLE → DONE on `start` when `word_count` = 0; no memory access occurs.
  - READ → WAIT unconditionally.
  - WAIT → HOLD unconditionally.
  - HOLD → READ on handshake when `remaining` > 1.
  - HOLD → DONE on handshake when `remaining` = 1.
  - DONE → IDLE unconditionally.
- On accepted `start`:
  - `addr` ← `base_addr`, `remaining` ← `word_count`.
  - `bad_trit` clears to 0.
- READ: `mem_read` = 1 and `mem_address` = `addr` for exactly one cycle. `mem_read` is 0 in every other state.
- WAIT → HOLD edge:
  - `out_data` ← `mem_read_data` and `out_addr` ← `addr`.
  - `out_last` ← (`remaining` = 1).
  - `bad_trit` is set if any of the 9 trit pairs equals 2'b11.
- HOLD: `out_valid` = 1. A handshake is `out_valid` && `out_ready` at a rising edge.
  - On handshake, `addr` ← `addr` + 1 modulo 2^ADDR_WIDTH (wraps, e.g. 0x3FFFF → 0) and `remaining` ← `remaining` − 1.
  - `out_data`, `out_addr` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.
- DONE: `done` = 1 for one cycle, `busy` still 1; next state IDLE.
- `start` is ignored in every state except IDLE.
- `bad_trit` holds its value through IDLE until the next accepted `start`.
- `out_ready` has no effect outside HOLD.

## Timing
- Reset (`reset` low at an edge) takes effect from any state, mid-burst included:
  - state ← IDLE and the in-flight word is discarded.
  - `mem_read`, `out_valid`, `out_last`, `busy`, `done`, `bad_trit` are 0.
  - `out_data`, `out_addr`, `mem_address` are 0.
- Latency, with `start` accepted at edge E:
  - `mem_read` is high in the cycle after E.
  - `out_valid` rises after edge E+2.
- Throughput: one word per 3 cycles when `out_ready` is held high. A handshake at edge H issues the next `mem_read` in the cycle after H.
- Completion: handshake of the last word at edge H → `done` high in the cycle after H, `busy` falls one cycle later.
- Zero-count start at E → `done` high in the cycle after E.
- `start` is accepted again only once the block is back in IDLE. A new burst cannot overlap the previous one.

## Test plan
- Reset mid-burst:
  - Stimulus: hold `reset` low while in HOLD.
  - Required: next cycle all outputs zero and state IDLE.
  - Then `start` with base 0x10, count 2 → words 0x10 and 0x11 stream normally.
- Basic burst:
  - Stimulus: memory[0x20..0x23] = 0x00001, 0x00002, 0x2AAAA, 0x15555; `start` with base 0x20, count 4; `out_ready` held 1.
  - Required: four transfers in order, 3 cycles apart, addresses 0x20–0x23; `out_last` only on 0x23; `done` pulse; `bad_trit` = 0.
- Backpressure:
  - Stimulus: same burst, `out_ready` low 5 cycles per word.
  - Required: `out_data`, `out_addr` and `out_last` stable while stalled; no extra `mem_read` pulses; exactly 4 reads total.
- Illegal trit:
  - Stimulus: memory[0x5] = 0x00003; `start` with base 0x5, count 1.
  - Required: word 0x00003 delivered, `bad_trit` = 1 and stays 1 after `done`.
  - Then `start` with count 0 → `bad_trit` clears, `done` pulses one cycle after start, no `mem_read` issued.
- Wrap-around:
  - Stimulus: `start` with base 0x3FFFE, count 3.
  - Required: addresses 0x3FFFE, 0x3FFFF, 0x00000; `out_last` only on 0x00000.
- Start while busy:
  - Stimulus: pulse `start` with a different base during WAIT and during HOLD.
  - Required: pulses ignored; the original burst completes unchanged.
